// File: rtl/inst_fetch_ctrl_if.sv
// Bundles the fetch-stage control, instruction-memory port and debug read
// port between inst_fetch_ctrl and its surroundings.
interface inst_fetch_ctrl_if;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_addr;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_data;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC_plus4;
    logic        IF_Valid;
    logic        Dbg_req;
    logic [31:0] Dbg_addr;
    logic        Dbg_ack;
    logic [31:0] Dbg_data;
    logic        Halted;

    modport master (
        output Freeze, Branch_taken, Branch_addr, Mem_data, Dbg_req, Dbg_addr,
        input  Mem_addr, IF_Instruction, IF_PC_plus4, IF_Valid, Dbg_ack, Dbg_data, Halted
    );

    modport slave (
        input  Freeze, Branch_taken, Branch_addr, Mem_data, Dbg_req, Dbg_addr,
        output Mem_addr, IF_Instruction, IF_PC_plus4, IF_Valid, Dbg_ack, Dbg_data, Halted
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// MIPS IF stage sequencer: owns PC and the IF/ID register, handles stall and
// branch flush, and lends the instruction-memory port to a debug reader when idle.
module inst_fetch_ctrl #(
    parameter int unsigned ADDR_BITS   = 3,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter bit          HALT_AT_END = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_ctrl_if.slave   bus
);
    localparam int unsigned W = 32;

    typedef enum logic [1:0] {START, RUN, HALT} state_t;

    state_t         state, state_n;
    logic [W-1:0]   pc, pc_n;
    logic [W-1:0]   if_instr, if_instr_n;
    logic [W-1:0]   if_pc4, if_pc4_n;
    logic           if_valid, if_valid_n;
    logic           halted, halted_n;
    logic           dbg_ack;
    logic [W-1:0]   dbg_data;
    logic           gnt;
    logic           last_word;
    logic [W-1:0]   pc_plus4;
    logic [W-1:0]   branch_target;
    logic           unused_lo_bits;

    assign unused_lo_bits = ^{bus.Dbg_addr[1:0], bus.Branch_addr[1:0]};

    // Debug may only borrow the port when fetch is not using it this cycle
    assign gnt           = bus.Dbg_req & ((state != RUN) | (bus.Freeze & ~bus.Branch_taken));
    assign bus.Mem_addr  = gnt ? {bus.Dbg_addr[31:2], 2'b00} : pc;
    assign pc_plus4      = pc + W'(4);
    assign branch_target = {bus.Branch_addr[31:2], 2'b00};
    assign last_word     = (pc[ADDR_BITS+1:2] == {ADDR_BITS{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_instr_n = if_instr;
        if_pc4_n   = if_pc4;
        if_valid_n = if_valid;
        halted_n   = halted;
        unique case (state)
            START: state_n = RUN;
            RUN: begin
                if (bus.Branch_taken) begin
                    pc_n       = branch_target;
                    if_instr_n = '0;
                    if_valid_n = 1'b0;
                end else if (!bus.Freeze) begin
                    pc_n       = pc_plus4;
                    if_instr_n = bus.Mem_data;
                    if_pc4_n   = pc_plus4;
                    if_valid_n = 1'b1;
                    if (HALT_AT_END && last_word) begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end
                end
            end
            HALT: begin
                // Only a redirect from an older in-flight branch can restart fetch
                if_instr_n = '0;
                if_valid_n = 1'b0;
                if (bus.Branch_taken) begin
                    state_n  = RUN;
                    pc_n     = branch_target;
                    halted_n = 1'b0;
                end
            end
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_instr <= '0;
            if_pc4   <= '0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            pc       <= pc_n;
            if_instr <= if_instr_n;
            if_pc4   <= if_pc4_n;
            if_valid <= if_valid_n;
            halted   <= halted_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_ack  <= 1'b0;
            dbg_data <= '0;
        end else begin
            dbg_ack <= gnt;
            if (gnt) begin
                dbg_data <= bus.Mem_data;
            end
        end
    end

    assign bus.IF_Instruction = if_instr;
    assign bus.IF_PC_plus4    = if_pc4;
    assign bus.IF_Valid       = if_valid;
    assign bus.Halted         = halted;
    assign bus.Dbg_ack        = dbg_ack;
    assign bus.Dbg_data       = dbg_data;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: stimulus queues expected fetches and
// debug reads, a negedge monitor pops them as the DUT presents them.
module tb_inst_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(
        .ADDR_BITS   (3),
        .RESET_PC    (32'h0),
        .HALT_AT_END (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [8];
    assign bus.Mem_data = mem[bus.Mem_addr[4:2]];

    function automatic logic [31:0] word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h111;
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_t;

    fetch_t      exp_fetch [$];
    logic [31:0] exp_dbg   [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input int i, input logic [31:0] pc4);
        fetch_t f;
        f.instr = word(i);
        f.pc4   = pc4;
        exp_fetch.push_back(f);
    endtask

    // Monitor: a fetch result is new when valid rises or the PC+4 changes
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc4   = '0;
    always @(negedge clk) begin
        if (bus.IF_Valid === 1'b1 && (!prev_valid || bus.IF_PC_plus4 !== prev_pc4)) begin
            if (exp_fetch.size() == 0) begin
                check("unexpected_fetch", bus.IF_PC_plus4, 32'hDEAD_BEEF);
            end else begin
                fetch_t f;
                f = exp_fetch.pop_front();
                check("fetch_instr", bus.IF_Instruction, f.instr);
                check("fetch_pc4", bus.IF_PC_plus4, f.pc4);
            end
        end
        if (bus.Dbg_ack === 1'b1) begin
            if (exp_dbg.size() == 0) begin
                check("unexpected_dbg_ack", bus.Dbg_data, 32'hDEAD_BEEF);
            end else begin
                check("dbg_data", bus.Dbg_data, exp_dbg.pop_front());
            end
        end
        prev_valid = (bus.IF_Valid === 1'b1);
        prev_pc4   = bus.IF_PC_plus4;
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = word(i);
        bus.Freeze       = 1'b0;
        bus.Branch_taken = 1'b0;
        bus.Branch_addr  = '0;
        bus.Dbg_req      = 1'b0;
        bus.Dbg_addr     = '0;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(bus.IF_Valid), 32'd0);
        check("rst_halted", 32'(bus.Halted), 32'd0);
        check("rst_pc", bus.Mem_addr, 32'h0);
        rst = 1'b0;

        // START: one idle cycle
        step();
        check("start_no_fetch", 32'(bus.IF_Valid), 32'd0);
        check("start_pc", bus.Mem_addr, 32'h0);

        // Free-running fetch of words 0..7 then HALT
        for (int i = 0; i < 8; i++) push_fetch(i, 32'(4 * (i + 1)));
        for (int i = 0; i < 7; i++) step();
        check("pre_halt", 32'(bus.Halted), 32'd0);
        step();
        check("halt_on_last", 32'(bus.Halted), 32'd1);
        check("halt_last_valid", 32'(bus.IF_Valid), 32'd1);
        bus.Freeze = 1'b1;
        step();
        check("halt_valid_drop", 32'(bus.IF_Valid), 32'd0);
        check("halt_instr_zero", bus.IF_Instruction, 32'h0);
        check("halt_pc_held", bus.Mem_addr, 32'h20);
        bus.Freeze = 1'b0;

        // Debug read in HALT
        bus.Dbg_req  = 1'b1;
        bus.Dbg_addr = 32'hC;
        exp_dbg.push_back(word(3));
        #1;
        check("halt_dbg_addr", bus.Mem_addr, 32'hC);
        step();
        bus.Dbg_req = 1'b0;
        check("halt_dbg_ack", 32'(bus.Dbg_ack), 32'd1);
        check("still_halted", 32'(bus.Halted), 32'd1);

        // HALT exit by branch to 0x4
        bus.Branch_taken = 1'b1;
        bus.Branch_addr  = 32'h4;
        step();
        bus.Branch_taken = 1'b0;
        check("exit_halted", 32'(bus.Halted), 32'd0);
        check("exit_valid", 32'(bus.IF_Valid), 32'd0);
        check("exit_pc", bus.Mem_addr, 32'h4);
        push_fetch(1, 32'h8);
        step();

        // Freeze 3 cycles at PC=0x8
        bus.Freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_pc", bus.Mem_addr, 32'h8);
            check("frz_pc4", bus.IF_PC_plus4, 32'h8);
            check("frz_instr", bus.IF_Instruction, word(1));
        end
        bus.Freeze = 1'b0;
        push_fetch(2, 32'hC);
        step();
        check("resume_pc", bus.Mem_addr, 32'hC);

        // Branch beats Freeze, target aligned down
        bus.Freeze       = 1'b1;
        bus.Branch_taken = 1'b1;
        bus.Branch_addr  = 32'h13;
        step();
        bus.Freeze       = 1'b0;
        bus.Branch_taken = 1'b0;
        check("br_pc", bus.Mem_addr, 32'h10);
        check("br_valid", 32'(bus.IF_Valid), 32'd0);
        check("br_instr", bus.IF_Instruction, 32'h0);
        check("br_pc4_held", bus.IF_PC_plus4, 32'hC);
        push_fetch(4, 32'h14);
        step();

        // Debug request while fetch owns the port: no grant
        bus.Dbg_req  = 1'b1;
        bus.Dbg_addr = 32'h17;
        push_fetch(5, 32'h18);
        step();
        check("dbg_blocked", 32'(bus.Dbg_ack), 32'd0);

        // Freeze lets debug in; held request reads every cycle
        bus.Freeze = 1'b1;
        exp_dbg.push_back(word(5));
        exp_dbg.push_back(word(5));
        #1;
        check("dbg_mem_addr", bus.Mem_addr, 32'h14);
        step();
        step();
        bus.Dbg_req = 1'b0;
        #1;
        check("dbg_pc_held", bus.Mem_addr, 32'h18);
        step();
        check("dbg_ack_drop", 32'(bus.Dbg_ack), 32'd0);

        // Branch to last index does not halt; fetching it does
        bus.Freeze       = 1'b0;
        bus.Branch_taken = 1'b1;
        bus.Branch_addr  = 32'h1C;
        step();
        bus.Branch_taken = 1'b0;
        check("br_last_no_halt", 32'(bus.Halted), 32'd0);
        push_fetch(7, 32'h20);
        step();
        check("last_fetch_halt", 32'(bus.Halted), 32'd1);
        step();

        // Async reset during a granted debug read
        bus.Dbg_req  = 1'b1;
        bus.Dbg_addr = 32'h8;
        #3;
        rst = 1'b1;
        #1;
        check("arst_ack", 32'(bus.Dbg_ack), 32'd0);
        check("arst_dbg_data", bus.Dbg_data, 32'h0);
        check("arst_pc4", bus.IF_PC_plus4, 32'h0);
        check("arst_halted", 32'(bus.Halted), 32'd0);
        step();
        bus.Dbg_req = 1'b0;
        #1;
        check("arst_pc", bus.Mem_addr, 32'h0);
        step();
        rst = 1'b0;

        // PC wraps from 0xFFFFFFFC to 0
        step();
        bus.Branch_taken = 1'b1;
        bus.Branch_addr  = 32'hFFFF_FFF8;
        step();
        bus.Branch_taken = 1'b0;
        check("wrap_br_pc", bus.Mem_addr, 32'hFFFF_FFF8);
        push_fetch(6, 32'hFFFF_FFFC);
        push_fetch(7, 32'h0);
        step();
        step();
        check("wrap_pc", bus.Mem_addr, 32'h0);
        check("wrap_halt", 32'(bus.Halted), 32'd1);

        step();
        step();
        check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
        check("dbg_queue_empty", 32'(exp_dbg.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
